cp0_exc_ctrl: RTL and testbench



---
 rtl/cp0_exc_ctrl_pkg.sv | 57 +++++
 rtl/cp0_exc_ctrl_int_arb.sv | 35 +++
 rtl/cp0_exc_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exc_ctrl_pkg.sv
// cp0_exc_ctrl_pkg
//   Shared CP0 definitions for the exception sequencer: register numbers,
//   ExcCode values, Status/Cause field positions, the exception vector,
//   FSM state encodings and the Cause word builder.
//   Imported by cp0_int_arb and cp0_exc_ctrl.
package cp0_exc_ctrl_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // ExcCode values
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_t;

  // Status field positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_HW = 10;  // IM[2] is the first hardware interrupt mask

  // Exception entry address
  localparam logic [31:0] CP0_EXC_VECTOR = 32'hBFC00380;

  // Sequencer states
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_W_BADV   = 3'd1;
  localparam logic [2:0] S_W_EPC    = 3'd2;
  localparam logic [2:0] S_W_CAUSE  = 3'd3;
  localparam logic [2:0] S_W_STATUS = 3'd4;
  localparam logic [2:0] S_W_ERET   = 3'd5;
  localparam logic [2:0] S_REDIRECT = 3'd6;

  // Winner of the IDLE-cycle request arbitration
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_EXC,
    SEL_ERET,
    SEL_INT,
    SEL_MTC0
  } req_sel_t;

  // Cause: BD at 31, IP[7:2] at 15:10, ExcCode at 6:2
  function automatic logic [31:0] make_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] code);
    return {bd, 15'b0, ip, 3'b0, code, 2'b0};
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_int_arb.sv
// cp0_int_arb
//   Combinational interrupt-pending detection and IDLE-cycle request select.
//   Priority: exception > eret > interrupt > mtc0.
// Ports:
//   exc_valid, eret, mtc0_valid : commit-stage requests
//   hw_int                      : raw hardware interrupt lines
//   im_hw                       : Status.IM[7:2]
//   ie, exl                     : Status.IE / Status.EXL
//   int_pending                 : an unmasked interrupt may be taken
//   sel                         : winning request
module cp0_int_arb
  import cp0_exc_ctrl_pkg::*;
(
  input  logic       exc_valid,
  input  logic       eret,
  input  logic       mtc0_valid,
  input  logic [5:0] hw_int,
  input  logic [5:0] im_hw,
  input  logic       ie,
  input  logic       exl,
  output logic       int_pending,
  output req_sel_t   sel
);

  assign int_pending = (|(hw_int & im_hw)) & ie & ~exl;

  always_comb begin
    sel = SEL_NONE;
    if (exc_valid)        sel = SEL_EXC;
    else if (eret)        sel = SEL_ERET;
    else if (int_pending) sel = SEL_INT;
    else if (mtc0_valid)  sel = SEL_MTC0;
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl
//   Exception/interrupt sequencer in front of the CP0 register file.
//   Serialises BadVAddr/EPC/Cause/Status writes onto the single write port,
//   holds the pipeline via busy and ends each sequence with a one-cycle flush.
//   Optional feature macro: CP0_BADVADDR_EN (adds the W_BADV state so that
//   AdEL/AdES write BadVAddr).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   exc_* , eret, mtc0_*          : commit-stage requests (sampled in IDLE only)
//   hw_int, int_pc                : interrupt lines and interrupt EPC
//   busy, flush, redirect_pc      : pipeline control
//   cp0_waddr, cp0_wen, cp0_wdata : register file write port
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = CP0_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic        mtc0_valid,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [5:0]  hw_int,
  input  logic [31:0] int_pc,
  output logic        busy,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [4:0]  cp0_waddr,
  output logic [3:0]  cp0_wen,
  output logic [31:0] cp0_wdata
);

  logic [2:0]  state_reg, state_next;
  logic [31:0] status_reg, epc_reg;
  logic [4:0]  code_reg;
  logic [31:0] pc_reg;
  logic        bd_reg;
  logic [5:0]  ip_reg;
  logic        exl_cap_reg;    // EXL as seen when the exception was captured
  logic        eret_path_reg;  // REDIRECT target selects EPC instead of vector

`ifdef CP0_BADVADDR_EN
  logic [31:0] badv_reg;
`else
  logic        unused_badvaddr;
  assign unused_badvaddr = ^exc_badvaddr;
`endif

  logic       int_pending;
  req_sel_t   sel;
  logic       take_exc;
  logic [4:0] cap_code;
  logic       cap_addr_err;
  logic [31:0] epc_value, status_exl_set, status_exl_clr;

  cp0_int_arb u_arb (
    .exc_valid  (exc_valid),
    .eret       (eret),
    .mtc0_valid (mtc0_valid),
    .hw_int     (hw_int),
    .im_hw      (status_reg[ST_IM_HW +: 6]),
    .ie         (status_reg[ST_IE]),
    .exl        (status_reg[ST_EXL]),
    .int_pending(int_pending),
    .sel        (sel)
  );

  assign take_exc = (state_reg == S_IDLE) && (sel == SEL_EXC || sel == SEL_INT);
  assign cap_code = (sel == SEL_INT) ? EXC_INT : exc_code;
`ifdef CP0_BADVADDR_EN
  assign cap_addr_err = (cap_code == EXC_ADEL) || (cap_code == EXC_ADES);
`else
  assign cap_addr_err = 1'b0;
`endif

  assign epc_value      = bd_reg ? (pc_reg - 32'd4) : pc_reg;
  assign status_exl_set = {status_reg[31:2], 1'b1, status_reg[0]};
  assign status_exl_clr = {status_reg[31:2], 1'b0, status_reg[0]};

  // busy covers the request cycle itself so the pipeline stalls immediately
  assign busy = ~rst & ((state_reg != S_IDLE) | exc_valid | eret | int_pending);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (take_exc) begin
          if (cap_addr_err)            state_next = S_W_BADV;
          else if (status_reg[ST_EXL]) state_next = S_W_CAUSE;
          else                         state_next = S_W_EPC;
        end else if (sel == SEL_ERET) begin
          state_next = S_W_ERET;
        end
      end
`ifdef CP0_BADVADDR_EN
      S_W_BADV:   state_next = exl_cap_reg ? S_W_CAUSE : S_W_EPC;
`endif
      S_W_EPC:    state_next = S_W_CAUSE;
      S_W_CAUSE:  state_next = S_W_STATUS;
      S_W_STATUS: state_next = S_REDIRECT;
      S_W_ERET:   state_next = S_REDIRECT;
      S_REDIRECT: state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cp0_waddr   = '0;
    cp0_wen     = '0;
    cp0_wdata   = '0;
    flush       = 1'b0;
    redirect_pc = '0;
    case (state_reg)
      S_IDLE: begin
        // MTC0 is a same-cycle pass-through when nothing outranks it
        if (sel == SEL_MTC0) begin
          cp0_waddr = mtc0_addr;
          cp0_wen   = 4'hF;
          cp0_wdata = mtc0_data;
        end
      end
`ifdef CP0_BADVADDR_EN
      S_W_BADV: begin
        cp0_waddr = CP0_BADVADDR;
        cp0_wen   = 4'hF;
        cp0_wdata = badv_reg;
      end
`endif
      S_W_EPC: begin
        cp0_waddr = CP0_EPC;
        cp0_wen   = 4'hF;
        cp0_wdata = epc_value;
      end
      S_W_CAUSE: begin
        cp0_waddr = CP0_CAUSE;
        cp0_wen   = 4'hF;
        // a nested exception leaves EPC alone, so BD would be meaningless
        cp0_wdata = make_cause(bd_reg & ~exl_cap_reg, ip_reg, code_reg);
      end
      S_W_STATUS: begin
        cp0_waddr = CP0_STATUS;
        cp0_wen   = 4'hF;
        cp0_wdata = status_exl_set;
      end
      S_W_ERET: begin
        cp0_waddr = CP0_STATUS;
        cp0_wen   = 4'hF;
        cp0_wdata = status_exl_clr;
      end
      S_REDIRECT: begin
        flush       = 1'b1;
        redirect_pc = eret_path_reg ? epc_reg : EXC_VECTOR;
      end
      default: ;
    endcase
    // a reset cycle must not leak a write from an aborted sequence
    if (rst) begin
      cp0_waddr   = '0;
      cp0_wen     = '0;
      cp0_wdata   = '0;
      flush       = 1'b0;
      redirect_pc = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      status_reg    <= '0;
      epc_reg       <= '0;
      code_reg      <= '0;
      pc_reg        <= '0;
      bd_reg        <= 1'b0;
      ip_reg        <= '0;
      exl_cap_reg   <= 1'b0;
      eret_path_reg <= 1'b0;
`ifdef CP0_BADVADDR_EN
      badv_reg      <= '0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (take_exc) begin
            code_reg      <= cap_code;
            pc_reg        <= (sel == SEL_INT) ? int_pc : exc_pc;
            bd_reg        <= (sel == SEL_INT) ? 1'b0 : exc_bd;
            ip_reg        <= hw_int;
            exl_cap_reg   <= status_reg[ST_EXL];
            eret_path_reg <= 1'b0;
`ifdef CP0_BADVADDR_EN
            badv_reg      <= exc_badvaddr;
`endif
          end else if (sel == SEL_ERET) begin
            eret_path_reg <= 1'b1;
          end else if (sel == SEL_MTC0) begin
            if (mtc0_addr == CP0_STATUS) status_reg <= mtc0_data;
            if (mtc0_addr == CP0_EPC)    epc_reg    <= mtc0_data;
          end
        end
        S_W_EPC:    epc_reg    <= epc_value;
        S_W_STATUS: status_reg <= status_exl_set;
        S_W_ERET:   status_reg <= status_exl_clr;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;
  import cp0_exc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_bd = 1'b0;
  logic [31:0] exc_badvaddr = '0;
  logic        eret = 1'b0;
  logic        mtc0_valid = 1'b0;
  logic [4:0]  mtc0_addr = '0;
  logic [31:0] mtc0_data = '0;
  logic [5:0]  hw_int = '0;
  logic [31:0] int_pc = '0;
  logic        busy, flush;
  logic [31:0] redirect_pc;
  logic [4:0]  cp0_waddr;
  logic [3:0]  cp0_wen;
  logic [31:0] cp0_wdata;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .eret(eret),
    .mtc0_valid(mtc0_valid), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .hw_int(hw_int), .int_pc(int_pc),
    .busy(busy), .flush(flush), .redirect_pc(redirect_pc),
    .cp0_waddr(cp0_waddr), .cp0_wen(cp0_wen), .cp0_wdata(cp0_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_flush;
    logic [4:0]  addr;
    logic [31:0] data;
    int          at;
  } ev_t;

  ev_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Scoreboard: every write or flush the DUT produces is popped and compared
  always @(negedge clk) begin : mon
    ev_t e;
    if (rst === 1'b0) begin
      if (cp0_wen !== 4'h0) begin
        $display("write cyc=%0d addr=%0d wen=%h data=%h", cyc, cp0_waddr, cp0_wen, cp0_wdata);
        total++;
        if (exp_q.size() == 0 || exp_q[0].is_flush) begin
          bad++;
          $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%h, required no write here",
                   cyc, cp0_waddr, cp0_wdata);
        end else begin
          e = exp_q.pop_front();
          total++;
          if (cp0_wen !== 4'hF) begin
            bad++;
            $display("FAIL write_wen cyc=%0d got %h required F", cyc, cp0_wen);
          end
          total++;
          if (cp0_waddr !== e.addr) begin
            bad++;
            $display("FAIL write_addr cyc=%0d got %0d required %0d", cyc, cp0_waddr, e.addr);
          end
          total++;
          if (cp0_wdata !== e.data) begin
            bad++;
            $display("FAIL write_data cyc=%0d addr=%0d got %h required %h", cyc, e.addr, cp0_wdata, e.data);
          end
          total++;
          if (cyc != e.at) begin
            bad++;
            $display("FAIL write_cycle addr=%0d got cyc %0d required cyc %0d", e.addr, cyc, e.at);
          end
        end
      end
      if (flush !== 1'b0) begin
        $display("flush cyc=%0d redirect=%h", cyc, redirect_pc);
        total++;
        if (exp_q.size() == 0 || !exp_q[0].is_flush) begin
          bad++;
          $display("FAIL unexpected_flush cyc=%0d got redirect=%h, required no flush here", cyc, redirect_pc);
        end else begin
          e = exp_q.pop_front();
          total++;
          if (redirect_pc !== e.data) begin
            bad++;
            $display("FAIL redirect_pc cyc=%0d got %h required %h", cyc, redirect_pc, e.data);
          end
          total++;
          if (cyc != e.at) begin
            bad++;
            $display("FAIL flush_cycle got cyc %0d required cyc %0d", cyc, e.at);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [4:0] a, input logic [31:0] d, input int at);
    ev_t e;
    e.is_flush = 1'b0; e.addr = a; e.data = d; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic push_f(input logic [31:0] d, input int at);
    ev_t e;
    e.is_flush = 1'b1; e.addr = '0; e.data = d; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    exc_valid = 1'b0; eret = 1'b0; mtc0_valid = 1'b0;
    exc_code = '0; exc_pc = '0; exc_bd = 1'b0; exc_badvaddr = '0;
    mtc0_addr = '0; mtc0_data = '0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (exp_q.size() == 0) ok = 1'b1;
    tick();
  endtask

  task automatic mtc0_once(input logic [4:0] a, input logic [31:0] d);
    tick();
    mtc0_valid = 1'b1; mtc0_addr = a; mtc0_data = d;
    push_w(a, d, cyc);
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (3) tick();
    mtc0_valid = 1'b1; mtc0_addr = 5'd14; mtc0_data = 32'hAAAA5555;
    #1;
    total++;
    if (cp0_wen !== 4'h0) begin
      bad++;
      $display("FAIL reset_wen_during_rst got %h required 0", cp0_wen);
    end
    clear_inputs();
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b required 0", busy); end
    total++;
    if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got %b required 0", flush); end
    total++;
    if (cp0_wen !== 4'h0) begin bad++; $display("FAIL reset_wen got %h required 0", cp0_wen); end
    total++;
    if (cp0_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got %0d required 0", cp0_waddr); end
    total++;
    if (cp0_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got %h required 0", cp0_wdata); end
    total++;
    if (redirect_pc !== 32'd0) begin bad++; $display("FAIL reset_redirect got %h required 0", redirect_pc); end
  endtask

  task automatic test_ov_exception();
    int base;
    bit ok;
    tick();
    exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'hBFC00100; exc_bd = 1'b0;
    base = cyc;
    push_w(5'd14, 32'hBFC00100, base + 1);
    push_w(5'd13, 32'h00000030, base + 2);
    push_w(5'd12, 32'h00000002, base + 3);
    push_f(32'hBFC00380, base + 4);
    #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL ov_busy_request_cycle got %b required 1", busy); end
    tick();
    clear_inputs();
    #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL ov_busy_in_sequence got %b required 1", busy); end
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ov_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ov_busy_after got %b required 0", busy); end
  endtask

  task automatic test_mtc0_eret();
    int base;
    bit ok;
    tick();
    mtc0_valid = 1'b1; mtc0_addr = 5'd14; mtc0_data = 32'h00001234;
    base = cyc;
    push_w(5'd14, 32'h00001234, base);
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL mtc0_busy got %b required 0", busy); end
    tick();
    clear_inputs();
    eret = 1'b1;
    base = cyc;
    push_w(5'd12, 32'h00000000, base + 1);
    push_f(32'h00001234, base + 2);
    #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL eret_busy got %b required 1", busy); end
    tick();
    clear_inputs();
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL eret_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_addr_error();
    int base;
    int off;
    bit ok;
    tick();
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'hBFC00204; exc_bd = 1'b1;
    exc_badvaddr = 32'h00000003;
    base = cyc;
`ifdef CP0_BADVADDR_EN
    push_w(5'd8, 32'h00000003, base + 1);
    off = 1;
`else
    off = 0;
`endif
    push_w(5'd14, 32'hBFC00200, base + 1 + off);
    push_w(5'd13, 32'h80000010, base + 2 + off);
    push_w(5'd12, 32'h00000002, base + 3 + off);
    push_f(32'hBFC00380, base + 4 + off);
    tick();
    clear_inputs();
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL adel_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_interrupt();
    int base;
    bit ok;
    mtc0_once(5'd12, 32'h00000401);
    hw_int = 6'b000001; int_pc = 32'h80001000;
    base = cyc;
    push_w(5'd14, 32'h80001000, base + 1);
    push_w(5'd13, 32'h00000400, base + 2);
    push_w(5'd12, 32'h00000403, base + 3);
    push_f(32'hBFC00380, base + 4);
    #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL int_busy_pending got %b required 1", busy); end
    tick();
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL int_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
    // hw_int still asserted, but EXL is now set: nothing may be taken
    repeat (4) tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL int_masked_by_exl busy got %b required 0", busy); end
    hw_int = '0;
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    mtc0_once(5'd12, 32'h00000000);
    // exception, eret and mtc0 together: only the exception runs
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h00000100; exc_bd = 1'b0;
    eret = 1'b1;
    mtc0_valid = 1'b1; mtc0_addr = 5'd14; mtc0_data = 32'h0000DEAD;
    base = cyc;
    push_w(5'd14, 32'h00000100, base + 1);
    push_w(5'd13, 32'h00000020, base + 2);
    push_w(5'd12, 32'h00000002, base + 3);
    push_f(32'hBFC00380, base + 4);
    tick();
    clear_inputs();
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL together_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_nested_exl();
    int base;
    bit ok;
    // EXL=1: no EPC write, no BD, flush one cycle earlier
    tick();
    exc_valid = 1'b1; exc_code = 5'd9; exc_pc = 32'h00000200; exc_bd = 1'b1;
    hw_int = 6'b000100;
    base = cyc;
    push_w(5'd13, 32'h00001024, base + 1);
    push_w(5'd12, 32'h00000002, base + 2);
    push_f(32'hBFC00380, base + 3);
    tick();
    clear_inputs();
    hw_int = '0;
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL nested_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
    // EPC must still hold the outer exception's PC
    tick();
    eret = 1'b1;
    base = cyc;
    push_w(5'd12, 32'h00000000, base + 1);
    push_f(32'h00000100, base + 2);
    tick();
    clear_inputs();
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL nested_eret_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    mtc0_once(5'd12, 32'h0000FF01);
    exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h00000300; exc_bd = 1'b0;
    base = cyc;
    push_w(5'd14, 32'h00000300, base + 1);
    tick();
    clear_inputs();
    tick();
    // now in W_CAUSE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (cp0_wen !== 4'h0) begin bad++; $display("FAIL rstmid_wen got %h required 0", cp0_wen); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b required 0", busy); end
    total++;
    if (flush !== 1'b0) begin bad++; $display("FAIL rstmid_flush got %b required 0", flush); end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rstmid_epc_written pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) tick();
    // shadows are zero: ERET writes Status 0 and redirects to EPC 0
    eret = 1'b1;
    base = cyc;
    push_w(5'd12, 32'h00000000, base + 1);
    push_f(32'h00000000, base + 2);
    tick();
    clear_inputs();
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rstmid_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_ov_exception();
    test_mtc0_eret();
    test_addr_error();
    test_interrupt();
    test_back_to_back();
    test_nested_exl();
    test_reset_mid();
    repeat (3) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL final_queue pending=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
